// File: rtl/inst_queue_gen_if.sv
// inst_queue_gen_if: front-end bundle, back-end dispatch and status signals of the instruction queue
interface inst_queue_gen_if #(
  parameter int FETCH_WIDTH    = 8,
  parameter int DISPATCH_WIDTH = 4,
  parameter int DEPTH          = 32,
  parameter int PKT_W          = 96
);
  logic                              flush_i;
  logic                              stall_i;
  logic                              decodeReady_i;
  logic [FETCH_WIDTH-1:0]            decodedVector_i;
  logic [FETCH_WIDTH*PKT_W-1:0]      decodedPackets_i;
  logic                              stallFetch_o;
  logic                              instBufferReady_o;
  logic [DISPATCH_WIDTH-1:0]         dispatchVector_o;
  logic [DISPATCH_WIDTH*PKT_W-1:0]   decodedPackets_o;
  logic [$clog2(DISPATCH_WIDTH):0]   branchCount_o;
  logic [$clog2(DEPTH):0]            instCount_o;
  modport master (
    output flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPackets_i,
    input  stallFetch_o, instBufferReady_o, dispatchVector_o, decodedPackets_o, branchCount_o, instCount_o
  );
  modport slave (
    input  flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPackets_i,
    output stallFetch_o, instBufferReady_o, dispatchVector_o, decodedPackets_o, branchCount_o, instCount_o
  );
endinterface

// File: rtl/inst_queue_gen.sv
// inst_queue_gen: circular instruction queue compacting sparse decode bundles and presenting in-order dispatch groups
module inst_queue_gen #(
  parameter int FETCH_WIDTH      = 8,
  parameter int DISPATCH_WIDTH   = 4,
  parameter int DEPTH            = 32,
  parameter int PKT_W            = 96,
  parameter int BR_BIT           = 90,
  parameter int PARTIAL_DISPATCH = 0
) (
  input logic clk,
  input logic reset,
  inst_queue_gen_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DISPATCH_WIDTH) + 1;
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] DISP   = CW'(DISPATCH_WIDTH);
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, wr_off;
  logic [CW-1:0]    cnt_q, cnt_d, avail, n_in, n_out;
  logic             accept;
  // write accepted valid slots back-to-back from the tail, skipping holes
  always_comb begin
    mem_d = mem_q;
    wr_off = '0;
    accept = q.decodeReady_i & ~q.stallFetch_o & ~q.flush_i;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (accept & q.decodedVector_i[k]) begin
        mem_d[tail_q + wr_off] = q.decodedPackets_i[k*PKT_W +: PKT_W];
        wr_off = wr_off + AW'(1);
      end
    end
    n_in = CW'(wr_off);
  end
  // present the head group; outputs depend only on registered state, so a fresh write is never bypassed
  always_comb begin
    q.stallFetch_o = cnt_q > THRESH;
    avail = (PARTIAL_DISPATCH != 0) ? ((cnt_q < DISP) ? cnt_q : DISP) : ((cnt_q >= DISP) ? DISP : '0);
    q.instBufferReady_o = avail != '0;
    q.dispatchVector_o = '0;
    q.decodedPackets_o = '0;
    q.branchCount_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      q.dispatchVector_o[k] = CW'(k) < avail;
      q.decodedPackets_o[k*PKT_W +: PKT_W] = mem_q[head_q + AW'(k)];
      q.branchCount_o = q.branchCount_o + BW'(q.dispatchVector_o[k] & mem_q[head_q + AW'(k)][BR_BIT]);
    end
    q.instCount_o = cnt_q;
  end
  // pointer and occupancy update; flush discards both the incoming bundle and this cycle's dispatch
  always_comb begin
    n_out = (~q.stall_i & ~q.flush_i) ? avail : '0;
    head_d = q.flush_i ? '0 : head_q + n_out[AW-1:0];
    tail_d = q.flush_i ? '0 : tail_q + n_in[AW-1:0];
    cnt_d = q.flush_i ? '0 : cnt_q + n_in - n_out;
  end
  // pointers and count reset asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
  // storage is never cleared, only overwritten
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule
